// File: rtl/key_schedule_iter.sv
// Iterative AES-128 key schedule: loads a cipher key, then produces one round key
// per consumer advance (one expansion cycle each) until round key 10 is consumed.
module key_schedule_iter #(
    parameter int unsigned NUM_ROUNDS = 10  // only 10 (AES-128) is supported
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [127:0] key_in,
    input  logic         advance,
    output logic [127:0] round_key,
    output logic [3:0]   round_idx,
    output logic         key_valid,
    output logic         busy,
    output logic         done
);

    localparam int unsigned KEY_W  = 128;
    localparam int unsigned IDX_W  = 4;
    localparam int unsigned WORD_W = 32;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_ROUNDS);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HOLD = 2'd1,
        ST_CALC = 2'd2
    } state_t;

    localparam logic [7:0] SBOX [0:255] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    function automatic logic [7:0] sbox(input logic [7:0] b);
        return SBOX[b];
    endfunction

    // Rcon for the round being produced: counter value n selects Rcon[n+1].
    function automatic logic [7:0] rcon(input logic [IDX_W-1:0] idx);
        logic [7:0] rc;
        case (idx)
            4'd0:    rc = 8'h01;
            4'd1:    rc = 8'h02;
            4'd2:    rc = 8'h04;
            4'd3:    rc = 8'h08;
            4'd4:    rc = 8'h10;
            4'd5:    rc = 8'h20;
            4'd6:    rc = 8'h40;
            4'd7:    rc = 8'h80;
            4'd8:    rc = 8'h1b;
            4'd9:    rc = 8'h36;
            default: rc = 8'h00;
        endcase
        return rc;
    endfunction

    state_t             r_state;
    state_t             w_state_nxt;
    logic [KEY_W-1:0]   r_key;
    logic [IDX_W-1:0]   r_round_idx;
    logic               r_key_valid;
    logic               r_busy;
    logic               r_done;

    logic [KEY_W-1:0]   w_key_nxt;
    logic [IDX_W-1:0]   w_idx_nxt;
    logic               w_key_valid_nxt;
    logic               w_busy_nxt;
    logic               w_done_nxt;

    logic [WORD_W-1:0]  w_rot;
    logic [WORD_W-1:0]  w_temp;
    logic [WORD_W-1:0]  w_n0;
    logic [WORD_W-1:0]  w_n1;
    logic [WORD_W-1:0]  w_n2;
    logic [WORD_W-1:0]  w_n3;
    logic [KEY_W-1:0]   w_expanded;

    // One FIPS-197 expansion step from the current round key.
    always_comb begin
        w_rot  = {r_key[23:0], r_key[31:24]};
        w_temp = {sbox(w_rot[31:24]), sbox(w_rot[23:16]), sbox(w_rot[15:8]), sbox(w_rot[7:0])}
                 ^ {rcon(r_round_idx), 24'h000000};
        w_n0   = r_key[127:96] ^ w_temp;
        w_n1   = r_key[95:64]  ^ w_n0;
        w_n2   = r_key[63:32]  ^ w_n1;
        w_n3   = r_key[31:0]   ^ w_n2;
        w_expanded = {w_n0, w_n1, w_n2, w_n3};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // advance beats start in HOLD simply because start is only looked at in IDLE.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (start)   w_state_nxt = ST_HOLD;
            ST_HOLD: if (advance) w_state_nxt = (r_round_idx == LAST_IDX) ? ST_IDLE : ST_CALC;
            ST_CALC: w_state_nxt = ST_HOLD;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        w_key_nxt       = r_key;
        w_idx_nxt       = r_round_idx;
        w_key_valid_nxt = (w_state_nxt == ST_HOLD);
        w_busy_nxt      = (w_state_nxt != ST_IDLE);
        w_done_nxt      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_key_nxt = key_in;
                    w_idx_nxt = '0;
                end
            end
            ST_HOLD: begin
                if (advance && (r_round_idx == LAST_IDX)) w_done_nxt = 1'b1;
            end
            ST_CALC: begin
                w_key_nxt = w_expanded;
                w_idx_nxt = r_round_idx + IDX_W'(1);
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_key       <= '0;
            r_round_idx <= '0;
            r_key_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_key       <= w_key_nxt;
            r_round_idx <= w_idx_nxt;
            r_key_valid <= w_key_valid_nxt;
            r_busy      <= w_busy_nxt;
            r_done      <= w_done_nxt;
        end
    end

    assign round_key = r_key;
    assign round_idx = r_round_idx;
    assign key_valid = r_key_valid;
    assign busy      = r_busy;
    assign done      = r_done;

endmodule

// File: tb/tb_key_schedule_iter.sv
// Scoreboard bench for key_schedule_iter using FIPS-197 Appendix A.1 / C.1 key vectors.
module tb_key_schedule_iter;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [127:0] key_in;
    logic         advance;
    logic [127:0] round_key;
    logic [3:0]   round_idx;
    logic         key_valid;
    logic         busy;
    logic         done;

    always #5 clk = ~clk;

    key_schedule_iter #(.NUM_ROUNDS(10)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .key_in    (key_in),
        .advance   (advance),
        .round_key (round_key),
        .round_idx (round_idx),
        .key_valid (key_valid),
        .busy      (busy),
        .done      (done)
    );

    typedef struct packed {
        logic         is_done;
        logic         chk_key;
        logic [3:0]   idx;
        logic [127:0] key;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_errors = 0;
    logic prev_valid = 1'b0;

    logic [127:0] rk [0:10];
    localparam logic [127:0] K1     = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] K2     = 128'hffeeddccbbaa99887766554433221100;
    localparam logic [127:0] K3     = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] K3_R10 = 128'h13111d7fe3944a17f307a78b4d2b30c5;

    // Monitor: each new key presentation and each done cycle consumes one expectation.
    exp_t e;
    always @(negedge clk) begin
        if (key_valid === 1'b1 && !prev_valid) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                n_errors++;
                $display("FAIL unexpected_key: got idx %0d key %h, nothing expected", round_idx, round_key);
            end else begin
                e = exp_q.pop_front();
                if (e.is_done || round_idx !== e.idx || (e.chk_key && round_key !== e.key)) begin
                    n_errors++;
                    $display("FAIL key_presentation: got idx %0d key %h, expected idx %0d key %h (done_expected=%0d)",
                             round_idx, round_key, e.idx, e.key, e.is_done);
                end
            end
        end
        if (done === 1'b1) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                n_errors++;
                $display("FAIL unexpected_done: done=1 with nothing expected");
            end else begin
                e = exp_q.pop_front();
                if (!e.is_done) begin
                    n_errors++;
                    $display("FAIL done_order: got done=1, expected key idx %0d", e.idx);
                end
            end
        end
        prev_valid = (key_valid === 1'b1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic push_key(input logic [3:0] idx, input logic [127:0] k, input logic ck);
        exp_t x;
        x.is_done = 1'b0;
        x.chk_key = ck;
        x.idx     = idx;
        x.key     = k;
        exp_q.push_back(x);
    endtask

    task automatic push_done();
        exp_t x;
        x.is_done = 1'b1;
        x.chk_key = 1'b0;
        x.idx     = 4'd0;
        x.key     = '0;
        exp_q.push_back(x);
    endtask

    task automatic do_start(input logic [127:0] k);
        push_key(4'd0, k, 1'b1);
        start  = 1'b1;
        key_in = k;
        tick();
        start  = 1'b0;
        chk("start_valid", 128'(key_valid), 128'd1);
        chk("start_busy", 128'(busy), 128'd1);
    endtask

    task automatic adv(input logic [3:0] idx, input logic [127:0] k, input logic ck);
        push_key(idx, k, ck);
        advance = 1'b1;
        tick();
        advance = 1'b0;
        chk("calc_valid_low", 128'(key_valid), 128'd0);
        tick();
        chk("hold_idx", 128'(round_idx), 128'(idx));
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_valid"}, 128'(key_valid), 128'd0);
        chk({tag, "_busy"},  128'(busy),      128'd0);
        chk({tag, "_done"},  128'(done),      128'd0);
        chk({tag, "_idx"},   128'(round_idx), 128'd0);
        chk({tag, "_key"},   round_key,       128'd0);
    endtask

    initial begin
        rk[0]  = K1;
        rk[1]  = 128'ha0fafe1788542cb123a339392a6c7605;
        rk[2]  = 128'hf2c295f27a96b9435935807a7359f67f;
        rk[3]  = 128'h3d80477d4716fe3e1e237e446d7a883b;
        rk[4]  = 128'hef44a541a8525b7fb671253bdb0bad00;
        rk[5]  = 128'hd4d1c6f87c839d87caf2b8bc11f915bc;
        rk[6]  = 128'h6d88a37a110b3efddbf98641ca0093fd;
        rk[7]  = 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f;
        rk[8]  = 128'head27321b58dbad2312bf5607f8d292f;
        rk[9]  = 128'hac7766f319fadc2128d12941575c006e;
        rk[10] = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;

        rst = 1'b1; start = 1'b0; advance = 1'b0; key_in = '0;
        tick();
        tick();
        chk_idle("reset");
        rst = 1'b0;

        // advance in IDLE has no effect
        advance = 1'b1;
        tick();
        advance = 1'b0;
        chk("idle_adv_busy", 128'(busy), 128'd0);
        chk("idle_adv_valid", 128'(key_valid), 128'd0);
        tick();

        // load, then walk to round 3 with a held CALC value check
        do_start(K1);
        chk("r0_key", round_key, K1);
        push_key(4'd1, rk[1], 1'b1);
        advance = 1'b1;
        tick();
        advance = 1'b0;
        chk("calc_key_held", round_key, K1);
        chk("calc_valid_low", 128'(key_valid), 128'd0);
        tick();
        chk("r1_key", round_key, rk[1]);
        for (int r = 2; r <= 3; r++) adv(4'(r), rk[r], 1'b1);

        // start in HOLD is ignored
        start = 1'b1; key_in = K2;
        tick();
        start = 1'b0;
        chk("hold_start_idx", 128'(round_idx), 128'd3);
        chk("hold_start_key", round_key, rk[3]);
        tick();
        chk("hold_start_valid", 128'(key_valid), 128'd1);
        for (int r = 4; r <= 10; r++) adv(4'(r), rk[r], 1'b1);
        chk("r10_key", round_key, rk[10]);

        // final advance: done pulse, then restart in the done cycle
        push_done();
        advance = 1'b1;
        tick();
        advance = 1'b0;
        chk("done_pulse", 128'(done), 128'd1);
        chk("done_busy", 128'(busy), 128'd0);
        chk("done_valid", 128'(key_valid), 128'd0);
        do_start(K1);
        chk("done_one_cycle", 128'(done), 128'd0);

        // reset during CALC at round 5
        for (int r = 1; r <= 5; r++) adv(4'(r), rk[r], 1'b1);
        advance = 1'b1;
        tick();
        advance = 1'b0;
        chk("calc5_valid_low", 128'(key_valid), 128'd0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk_idle("midreset");

        // fresh schedule from the Appendix C.1 key
        do_start(K3);
        for (int r = 1; r <= 9; r++) adv(4'(r), '0, 1'b0);
        adv(4'd10, K3_R10, 1'b1);
        chk("k3_r10_key", round_key, K3_R10);
        push_done();
        advance = 1'b1;
        tick();
        advance = 1'b0;
        chk("k3_done", 128'(done), 128'd1);
        tick();

        // advance held high: alternating valid/CALC, then a single done
        for (int r = 0; r <= 10; r++) push_key(4'(r), rk[r], 1'b1);
        push_done();
        start = 1'b1; key_in = K1;
        tick();
        start = 1'b0;
        advance = 1'b1;
        for (int c = 0; c <= 20; c++) begin
            chk("stream_valid", 128'(key_valid), ((c % 2) == 0) ? 128'd1 : 128'd0);
            tick();
        end
        chk("stream_done", 128'(done), 128'd1);
        chk("stream_busy", 128'(busy), 128'd0);
        tick();
        chk("stream_done_once", 128'(done), 128'd0);
        chk("stream_idle_busy", 128'(busy), 128'd0);
        advance = 1'b0;
        tick();
        tick();

        n_checks++;
        if (exp_q.size() != 0) begin
            n_errors++;
            $display("FAIL scoreboard_drain: got %0d outstanding expectations, expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/key_schedule_iter.md
KEY_SCHEDULE_ITER -- requirements
Module: key_schedule_iter

Interface
REQ-001 SHALL have parameter NUM_ROUNDS, default 10, giving the number of AES-128 round keys generated after round key 0; only the value 10 is supported.
REQ-002 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  input  1  synchronous, active-high reset, sampled on the rising edge of clk.
REQ-004 SHALL have port start  input  1  one-cycle request to load a new cipher key.
REQ-005 SHALL have port key_in  input  128  cipher key, sampled only on an accepted start; byte 0 is bits [127:120].
REQ-006 SHALL have port advance  input  1  consumer request to step to the next round key.
REQ-007 SHALL have port round_key  output  128  current round key, same byte order as key_in; feeds Expanded_Key of the round stages.
REQ-008 SHALL have port round_idx  output  4  index 0..10 of the key on round_key.
REQ-009 SHALL have port key_valid  output  1  round_key and round_idx are valid.
REQ-010 SHALL have port busy  output  1  high in every state except IDLE.
REQ-011 SHALL have port done  output  1  one-cycle pulse when round key 10 has been consumed.

Function
REQ-012 SHALL implement FSM states IDLE, HOLD and CALC, with one registered 128-bit key register and a 4-bit round counter.
REQ-013 In IDLE, start=1 SHALL load key_in into the key register, clear round_idx to 0 and enter HOLD; key_valid is 1 on the next cycle (latency 1).
REQ-014 In HOLD, key_valid SHALL be 1 and round_key SHALL equal the key register.
REQ-015 In HOLD, advance=1 with round_idx<10 SHALL enter CALC; key_valid is 0 in CALC.
REQ-016 In CALC, for exactly one cycle, the block SHALL compute the FIPS-197 key expansion: temp = SubWord(RotWord(w3)) XOR {Rcon[round_idx+1],24'h0}; w0'=w0^temp, w1'=w1^w0', w2'=w2^w1', w3'=w3^w2'.
REQ-017 In CALC, the block SHALL register the new words, increment round_idx and return to HOLD; advance-to-next-valid latency is therefore 2 cycles.
REQ-018 Rcon[1..10] SHALL be 01,02,04,08,10,20,40,80,1B,36 (hex), selected from a constant table indexed by the counter.
REQ-019 SubWord SHALL apply the standard AES forward S-box to each of the 4 bytes of the rotated word.
REQ-020 In HOLD, advance=1 with round_idx==10 SHALL return to IDLE and pulse done=1 for one cycle.
REQ-021 advance SHALL be ignored in IDLE and CALC.
REQ-022 start SHALL be ignored in HOLD and CALC; the key in flight is unaffected.
REQ-023 If start and advance are both 1 in HOLD, advance SHALL take effect and start SHALL be ignored.
REQ-024 In the IDLE cycle that follows the done pulse, start SHALL be accepted normally.
REQ-025 round_key and round_idx SHALL hold their last values while key_valid=0; consumers use them only when key_valid=1.
REQ-026 round_idx SHALL never exceed 10 and SHALL NOT wrap.

Reset
REQ-027 On rst=1 the block SHALL enter IDLE with key register 0, round_idx 0, key_valid 0, busy 0 and done 0.
REQ-028 rst SHALL take priority over start and advance in any state, including mid-schedule (HOLD or CALC), and no done pulse SHALL be produced.

Verification
REQ-029 The bench SHALL cover: start with key_in=2b7e151628aed2a6abf7158809cf4f3c -> next cycle key_valid=1, round_idx=0, round_key=key_in.
REQ-030 The bench SHALL cover: one advance from the REQ-029 state -> key_valid=0 for one cycle, then round_idx=1, round_key=a0fafe1788542cb123a339392a6c7605.
REQ-031 The bench SHALL cover: 10 advances from the REQ-029 state -> round_idx=10, round_key=d014f9a8c9ee2589e13f0cc8b6630ca6; the next advance -> done=1 for exactly one cycle, busy=0, key_valid=0.
REQ-032 The bench SHALL cover: start pulsed while in HOLD at round_idx=3 -> round_idx and round_key unchanged; a further advance yields round 4 of the original key.
REQ-033 The bench SHALL cover: rst asserted during CALC at round_idx=5 -> the following cycle is IDLE with all outputs 0; a new start with key_in=000102030405060708090a0b0c0d0e0f -> round 10 key 13111d7fe3944a17f307a78b4d2b30c5.
REQ-034 The bench SHALL cover: advance held high continuously after start -> keys with round_idx 0..10 each valid for exactly one cycle, separated by single CALC cycles, then a single done pulse.
